// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU op, operand selects and every datapath write enable.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [3:0] state,
    output logic       retire
);
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JUMP_R   = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;

    assign w_rtype = (opcode == 6'b000000);
    assign w_addu  = w_rtype && (funct == 6'b100001);
    assign w_subu  = w_rtype && (funct == 6'b100011);
    assign w_jr    = w_rtype && (funct == 6'b001000);
    assign w_ori   = (opcode == 6'b001101);
    assign w_lui   = (opcode == 6'b001111);
    assign w_lw    = (opcode == 6'b100011);
    assign w_sw    = (opcode == 6'b101011);
    assign w_beq   = (opcode == 6'b000100);
    assign w_j     = (opcode == 6'b000010);
    assign w_jal   = (opcode == 6'b000011);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    assign state = r_state;

    always_comb begin
        w_next     = S_FETCH;
        alu_ctrl   = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_en     = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                if (w_addu || w_subu)    w_next = S_EXEC_R;
                else if (w_jr)           w_next = S_JUMP_R;
                else if (w_ori || w_lui) w_next = S_EXEC_I;
                else if (w_lw || w_sw)   w_next = S_MEM_ADDR;
                else if (w_beq)          w_next = S_BRANCH;
                else if (w_j || w_jal)   w_next = S_JUMP;
                else                     w_next = S_FETCH;
                retire = (w_next == S_FETCH);
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctrl  = w_subu ? ALU_SUB : ALU_ADD;
                w_next    = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = w_lui ? ALU_LUI : ALU_OR;
                w_next    = S_ALU_WB;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                w_next    = w_lw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: w_next = S_MEM_WB;
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                retire    = 1'b1;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = w_rtype ? 2'b01 : 2'b00;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_en  = 1'b1;
                pc_src = 2'b10;
                retire = 1'b1;
                if (w_jal) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
            end
            S_JUMP_R: begin
                pc_en  = 1'b1;
                pc_src = 2'b11;
                retire = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        // Async reset must kill writes in the very cycle it rises.
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    logic w_unused;
    assign w_unused = ^{ALU_AND};
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control vectors are queued
// by the driver and checked by an independent negedge monitor.
module tb_mc_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
    logic [2:0] alu_ctrl;
    logic       alu_src_a, ext_op, pc_en, ir_write, mem_write, reg_write, retire;
    logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg;
    logic [3:0] state;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_op(ext_op), .pc_en(pc_en), .pc_src(pc_src), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .retire(retire)
    );

    always #5 clk = ~clk;

    // {state, alu, src_a, src_b, ext, pc_en, pc_src, ir, mw, rw, rd, m2r, retire}
    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic push(input string name, input logic [3:0] st, input logic [2:0] alu,
                        input logic sa, input logic [1:0] sb, input logic ext,
                        input logic pce, input logic [1:0] pcs, input logic ir,
                        input logic mw, input logic rw, input logic [1:0] rd,
                        input logic [1:0] m2r, input logic ret);
        exp_t e;
        e.name = name;
        e.v = {st, alu, sa, sb, ext, pce, pcs, ir, mw, rw, rd, m2r, ret};
        q.push_back(e);
    endtask

    task automatic p_rst(input string n);   push(n, 0, 3'b010, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0); endtask
    task automatic p_fetch(input string n); push(n, 0, 3'b010, 0, 2'b01, 0, 1, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0); endtask
    task automatic p_dec(input string n, input logic ret);
        push(n, 1, 3'b010, 0, 2'b11, 1, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, ret);
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
        opcode = op; funct = fn; zero = z;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [21:0] act;
            e = q.pop_front();
            act = {state, alu_ctrl, alu_src_a, alu_src_b, ext_op, pc_en, pc_src, ir_write,
                   mem_write, reg_write, reg_dst, mem_to_reg, retire};
            n_vec++;
            if (act !== e.v) begin
                n_miss++;
                $display("FAIL %s: got %06h expected %06h (state got %0d exp %0d)",
                         e.name, act, e.v, act[21:18], e.v[21:18]);
            end
        end
    end

    initial begin
        reset = 1'b1; opcode = 6'h3f; funct = 6'h3f; zero = 1'b1;
        p_rst("rst0"); p_rst("rst1"); p_rst("rst2");
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;

        // addu
        p_fetch("addu.f"); p_dec("addu.d", 0);
        push("addu.ex", 2, 3'b010, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        push("addu.wb", 8, 3'b010, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2'b01, 2'b00, 1);
        run(6'b000000, 6'b100001, 1'b1, 4);
        // subu
        p_fetch("subu.f"); p_dec("subu.d", 0);
        push("subu.ex", 2, 3'b110, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        push("subu.wb", 8, 3'b010, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2'b01, 2'b00, 1);
        run(6'b000000, 6'b100011, 1'b0, 4);
        // ori
        p_fetch("ori.f"); p_dec("ori.d", 0);
        push("ori.ex", 3, 3'b001, 1, 2'b10, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        push("ori.wb", 8, 3'b010, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 1);
        run(6'b001101, 6'b100001, 1'b1, 4);
        // lui
        p_fetch("lui.f"); p_dec("lui.d", 0);
        push("lui.ex", 3, 3'b011, 1, 2'b10, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        push("lui.wb", 8, 3'b010, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 1);
        run(6'b001111, 6'b000000, 1'b0, 4);
        // lw
        p_fetch("lw.f"); p_dec("lw.d", 0);
        push("lw.addr", 4, 3'b010, 1, 2'b10, 1, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        push("lw.rd",   5, 3'b010, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        push("lw.wb",   6, 3'b010, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b01, 1);
        run(6'b100011, 6'b000000, 1'b1, 5);
        // sw
        p_fetch("sw.f"); p_dec("sw.d", 0);
        push("sw.addr", 4, 3'b010, 1, 2'b10, 1, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        push("sw.wr",   7, 3'b010, 0, 2'b00, 0, 0, 2'b00, 0, 1, 0, 2'b00, 2'b00, 1);
        run(6'b101011, 6'b000000, 1'b1, 4);
        // beq taken / not taken
        p_fetch("beq1.f"); p_dec("beq1.d", 0);
        push("beq1.br", 9, 3'b110, 1, 2'b00, 0, 1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1);
        run(6'b000100, 6'b000000, 1'b1, 3);
        p_fetch("beq0.f"); p_dec("beq0.d", 0);
        push("beq0.br", 9, 3'b110, 1, 2'b00, 0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1);
        run(6'b000100, 6'b000000, 1'b0, 3);
        // j, jal, jr
        p_fetch("j.f"); p_dec("j.d", 0);
        push("j.jmp", 10, 3'b010, 0, 2'b00, 0, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 1);
        run(6'b000010, 6'b000000, 1'b0, 3);
        p_fetch("jal.f"); p_dec("jal.d", 0);
        push("jal.jmp", 10, 3'b010, 0, 2'b00, 0, 1, 2'b10, 0, 0, 1, 2'b10, 2'b10, 1);
        run(6'b000011, 6'b000000, 1'b0, 3);
        p_fetch("jr.f"); p_dec("jr.d", 0);
        push("jr.jmp", 11, 3'b010, 0, 2'b00, 0, 1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 1);
        run(6'b000000, 6'b001000, 1'b1, 3);
        // unsupported opcode, sll nop, unsupported funct
        p_fetch("bad.f"); p_dec("bad.d", 1);
        run(6'b111111, 6'b000000, 1'b1, 2);
        p_fetch("nop.f"); p_dec("nop.d", 1);
        run(6'b000000, 6'b000000, 1'b1, 2);
        p_fetch("badfn.f"); p_dec("badfn.d", 1);
        run(6'b000000, 6'b100000, 1'b1, 2);
        // reset raised inside MEM_WB of a lw
        p_fetch("lwr.f"); p_dec("lwr.d", 0);
        push("lwr.addr", 4, 3'b010, 1, 2'b10, 1, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        push("lwr.rd",   5, 3'b010, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        run(6'b100011, 6'b000000, 1'b1, 4);
        reset = 1'b1;
        p_rst("midrst0"); p_rst("midrst1");
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        // recovery: addu after reset
        p_fetch("rec.f"); p_dec("rec.d", 0);
        push("rec.ex", 2, 3'b010, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        push("rec.wb", 8, 3'b010, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2'b01, 2'b00, 1);
        run(6'b000000, 6'b100001, 1'b0, 4);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
